// File: rtl/pool_rr_arbiter.sv
// pool_rr_arbiter
//   Round-robin burst arbiter that shares one pooling accumulator between
//   NUM_CH channel streams. A channel holds the grant for exactly BURST_LEN
//   accepted beats. After that, one IDLE cycle picks the next requester,
//   searching from the channel after the last grant.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   arb_valid_in   per-channel valid
//   arb_data_in    per-channel data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   arb_ready_in   per-channel ready (only the granted channel, in BURST)
//   arb_valid_out  registered output valid
//   arb_data_out   registered data of the granted channel
//   arb_ch_out     channel id of arb_data_out
//   arb_last_out   high on the final beat of a burst
//   arb_ready_out  downstream ready
module pool_rr_arbiter #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 12,
  parameter  int BURST_LEN  = 10,
  localparam int CH_WIDTH   = $clog2(NUM_CH),
  localparam int CNT_WIDTH  = $clog2(BURST_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            arb_valid_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] arb_data_in,
  output logic [NUM_CH-1:0]            arb_ready_in,
  output logic                         arb_valid_out,
  output logic [DATA_WIDTH-1:0]        arb_data_out,
  output logic [CH_WIDTH-1:0]          arb_ch_out,
  output logic                         arb_last_out,
  input  logic                         arb_ready_out
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [CH_WIDTH-1:0]   rr_ptr;
  logic [CH_WIDTH-1:0]   grant;
  logic [CH_WIDTH-1:0]   next_grant;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic                  en;
  logic                  accept;
  logic                  last_beat;
  logic                  found;
  logic [CH_WIDTH:0]     idx;
  logic [DATA_WIDTH-1:0] slice [NUM_CH];

  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      slice[k] = arb_data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The output register can take a new beat when empty or being drained.
  assign en        = arb_ready_out | ~arb_valid_out;
  assign accept    = (state == BURST) && arb_valid_in[grant] && en;
  assign last_beat = (beat_cnt == CNT_WIDTH'(BURST_LEN - 1));

  always_comb begin
    arb_ready_in = '0;
    if (state == BURST) arb_ready_in[grant] = en;
  end

  // First requester at or after rr_ptr. The index carries one extra bit
  // so that the modulo wrap also works for non-power-of-2 NUM_CH.
  always_comb begin
    found      = 1'b0;
    next_grant = '0;
    idx        = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr} + (CH_WIDTH+1)'(i);
      if (idx >= (CH_WIDTH+1)'(NUM_CH)) idx = idx - (CH_WIDTH+1)'(NUM_CH);
      if (!found && arb_valid_in[idx[CH_WIDTH-1:0]]) begin
        found      = 1'b1;
        next_grant = idx[CH_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      beat_cnt      <= '0;
      arb_valid_out <= 1'b0;
      arb_data_out  <= '0;
      arb_ch_out    <= '0;
      arb_last_out  <= 1'b0;
    end else begin
      if (en) begin
        arb_valid_out <= accept;
        if (accept) begin
          arb_data_out <= slice[grant];
          arb_ch_out   <= grant;
          arb_last_out <= last_beat;
        end
      end

      case (state)
        IDLE: begin
          if (found) begin
            grant    <= next_grant;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            if (last_beat) begin
              rr_ptr <= (grant == CH_WIDTH'(NUM_CH - 1)) ? '0 : grant + CH_WIDTH'(1);
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_rr_arbiter.sv
module tb_pool_rr_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 12;
  localparam int BL  = 10;
  localparam int CW  = 2;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    arb_valid_in;
  logic [NCH*DW-1:0] arb_data_in;
  logic [NCH-1:0]    arb_ready_in;
  logic              arb_valid_out;
  logic [DW-1:0]     arb_data_out;
  logic [CW-1:0]     arb_ch_out;
  logic              arb_last_out;
  logic              arb_ready_out;

  int total = 0;
  int bad   = 0;
  int nb;
  logic r;

  pool_rr_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst          (rst),
    .arb_valid_in (arb_valid_in),
    .arb_data_in  (arb_data_in),
    .arb_ready_in (arb_ready_in),
    .arb_valid_out(arb_valid_out),
    .arb_data_out (arb_data_out),
    .arb_ch_out   (arb_ch_out),
    .arb_last_out (arb_last_out),
    .arb_ready_out(arb_ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slice(input int c, input logic [DW-1:0] v);
    arb_data_in[c*DW +: DW] = v;
  endtask

  // One accepted beat with no backpressure: ch must be readied, then the
  // beat appears at the output one cycle later.
  task automatic do_beat(input int ch, input logic [DW-1:0] v, input logic last);
    set_slice(ch, v);
    #1;
    chk("beat_rdy_in", 32'(arb_ready_in), 32'(1) << ch);
    step();
    chk("beat_valid", 32'(arb_valid_out), 32'd1);
    chk("beat_data",  32'(arb_data_out),  32'(v));
    chk("beat_ch",    32'(arb_ch_out),    32'(ch));
    chk("beat_last",  32'(arb_last_out),  32'(last));
  endtask

  // Starts in IDLE: one bubble cycle, then a full burst of ch.
  task automatic do_burst(input int ch, input logic [DW-1:0] base);
    chk("idle_rdy_in", 32'(arb_ready_in), 32'd0);
    step();
    chk("bubble_valid", 32'(arb_valid_out), 32'd0);
    for (int k = 0; k < BL; k++) do_beat(ch, base + DW'(k), k == BL - 1);
  endtask

  initial begin
    rst           = 1'b1;
    arb_valid_in  = '0;
    arb_data_in   = '0;
    arb_ready_out = 1'b1;
    step();
    chk("reset_valid",  32'(arb_valid_out), 32'd0);
    chk("reset_rdy_in", 32'(arb_ready_in),  32'd0);
    chk("reset_data",   32'(arb_data_out),  32'd0);
    chk("reset_ch",     32'(arb_ch_out),    32'd0);
    chk("reset_last",   32'(arb_last_out),  32'd0);
    rst = 1'b0;

    // Round-robin with every channel requesting: 0,1,2,3,0.
    arb_valid_in = 4'b1111;
    do_burst(0, 12'h000);
    do_burst(1, 12'h100);
    do_burst(2, 12'h200);
    do_burst(3, 12'h300);
    do_burst(0, 12'h010);

    // rr_ptr=1, only ch0 and ch3 requesting: ch3 then ch0.
    arb_valid_in = 4'b1001;
    do_burst(3, 12'h330);
    do_burst(0, 12'h020);

    // Single channel ch1, data = beat index, re-granted after one bubble.
    arb_valid_in = 4'b0010;
    do_burst(1, 12'h000);
    do_burst(1, 12'h000);

    // Backpressure on a ch2 burst, ready_out pattern 1,0,0,1 repeating.
    arb_valid_in = 4'b0100;
    chk("bp_idle_rdy_in", 32'(arb_ready_in), 32'd0);
    step();
    chk("bp_bubble_valid", 32'(arb_valid_out), 32'd0);
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      r = ((c % 4) == 0) || ((c % 4) == 3);
      arb_ready_out = r;
      set_slice(2, 12'h200 + DW'(nb));
      #1;
      chk("bp_rdy_in", 32'(arb_ready_in), r ? 32'h4 : 32'h0);
      step();
      if (r) nb++;
      chk("bp_valid", 32'(arb_valid_out), 32'd1);
      chk("bp_data",  32'(arb_data_out),  32'h200 + 32'(nb - 1));
      chk("bp_ch",    32'(arb_ch_out),    32'd2);
      chk("bp_last",  32'(arb_last_out),  32'(nb == BL));
    end
    arb_ready_out = 1'b1;

    // ch1 locked burst with a 5-cycle valid gap while ch2 requests.
    arb_valid_in = 4'b0110;
    chk("gap_idle_rdy_in", 32'(arb_ready_in), 32'd0);
    step();
    chk("gap_bubble_valid", 32'(arb_valid_out), 32'd0);
    for (int k = 0; k < 4; k++) do_beat(1, 12'h100 + DW'(k), 1'b0);
    arb_valid_in = 4'b0100;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("gap_rdy_in", 32'(arb_ready_in), 32'h2);
      step();
      chk("gap_valid", 32'(arb_valid_out), 32'd0);
    end
    arb_valid_in = 4'b0110;
    for (int k = 4; k < BL; k++) do_beat(1, 12'h100 + DW'(k), k == BL - 1);

    // ch2 now granted; reset after its fourth beat.
    chk("ch2_idle_rdy_in", 32'(arb_ready_in), 32'd0);
    step();
    chk("ch2_bubble_valid", 32'(arb_valid_out), 32'd0);
    for (int k = 0; k < 4; k++) do_beat(2, 12'h220 + DW'(k), 1'b0);
    #2;
    rst          = 1'b1;
    arb_valid_in = '0;
    #1;
    chk("midrst_valid",  32'(arb_valid_out), 32'd0);
    chk("midrst_rdy_in", 32'(arb_ready_in),  32'd0);
    chk("midrst_data",   32'(arb_data_out),  32'd0);
    chk("midrst_ch",     32'(arb_ch_out),    32'd0);
    chk("midrst_last",   32'(arb_last_out),  32'd0);
    step();
    step();
    rst = 1'b0;
    // ch1 and ch3 requesting: search restarts at 0, so ch1 wins.
    arb_valid_in = 4'b1010;
    do_burst(1, 12'h130);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_rr_arbiter.md
Name: pool_rr_arbiter

Overview:
- Round-robin burst arbiter that shares one pooling accumulator datapath between NUM_CH independent channel streams.
- Grants one channel for exactly BURST_LEN accepted beats, then rotates to the next requesting channel.
- Outputs one registered stream with channel-id and last-beat sideband; this stream feeds the shared accumulator's valid/ready input.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16)
- DATA_WIDTH, 12, sample width per channel
- BURST_LEN, 10, beats per grant (set equal to the accumulator pool size)
- CH_WIDTH, clog2(NUM_CH) from cnn1d_pkg, channel-id width (derived localparam)
- CNT_WIDTH, clog2(BURST_LEN+1), beat-counter width (derived localparam)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- arb_valid_in  input  NUM_CH  per-channel valid
- arb_data_in  input  NUM_CH*DATA_WIDTH  per-channel data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- arb_ready_in  output  NUM_CH  per-channel ready
- arb_valid_out  output  1  output valid
- arb_data_out  output  DATA_WIDTH  granted channel's data
- arb_ch_out  output  CH_WIDTH  channel id of arb_data_out
- arb_last_out  output  1  high on the final beat of a burst
- arb_ready_out  input  1  downstream ready

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - state=IDLE; rr_ptr=0; grant=0; beat_cnt=0.
  - arb_valid_out=0, arb_data_out=0, arb_ch_out=0, arb_last_out=0.
  - arb_ready_in all 0.
- Output stage:
  - Single register; stall = arb_valid_out & ~arb_ready_out.
  - Internal accept enable: en = arb_ready_out | ~arb_valid_out.
  - Registers hold on stall; when en=1 and no beat is accepted this cycle, arb_valid_out loads 0.
- FSM, IDLE:
  - arb_ready_in = 0.
  - If any arb_valid_in bit is set, grant = first set index searching rr_ptr, rr_ptr+1, ... modulo NUM_CH; beat_cnt=0; next state BURST.
  - Otherwise stay in IDLE.
  - IDLE always costs exactly one cycle; no beat is accepted in IDLE.
- FSM, BURST:
  - arb_ready_in[grant] = en; all other ready bits are 0.
  - Beat accepted when arb_valid_in[grant] & en. On accept:
    - arb_data_out = slice[grant]; arb_ch_out = grant; arb_valid_out = 1.
    - arb_last_out = (beat_cnt == BURST_LEN-1).
    - beat_cnt increments.
  - On the accept where beat_cnt == BURST_LEN-1: rr_ptr = (grant+1) mod NUM_CH; state to IDLE.
  - Grant is locked for the whole burst. If the granted channel deasserts valid, wait indefinitely; no preemption, no timeout. Other channels' valids are ignored while locked.
- Fairness: with all channels requesting continuously, grants cycle 0,1,2,...,NUM_CH-1,0. Each burst is followed by one IDLE bubble cycle.
- Throughput: BURST_LEN beats per BURST_LEN+1 cycles with no backpressure.
- Latency: input accept to arb_valid_out is 1 cycle.
- Wrap-around: rr_ptr and the grant search wrap modulo NUM_CH, including for non-power-of-2 NUM_CH. Indices >= NUM_CH are never granted.
- Simultaneous events:
  - Accept of the last beat coincident with a stall: impossible by construction, because en=0 blocks the accept.
  - Last-beat accept while a new channel asserts valid: the new channel is handled in the following IDLE cycle.
- Reset mid-burst: the burst is abandoned, the output is cleared and the next grant starts from channel 0. The partial burst is not replayed; the downstream accumulator is reset by the same rst.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-burst (after beat 4 of ch2); hold all valids low.
  - Required: arb_valid_out=0, arb_ready_in=0 within the reset cycle. After release, the first grant goes to the lowest requesting channel from 0.
- Single channel:
  - Stimulus: ch1 constant valid, data = beat index 0..9; BURST_LEN=10; arb_ready_out=1.
  - Required: 10 output beats, arb_ch_out=1, data 0..9, arb_last_out only on data 9. Then one bubble cycle, then ch1 re-granted.
- Round-robin:
  - Stimulus: all 4 channels continuously valid.
  - Required: bursts in order ch0,ch1,ch2,ch3,ch0. Exactly 10 beats each, each separated by one idle cycle.
- Skip non-requesters:
  - Stimulus: only ch0 and ch3 valid, rr_ptr=1 after the ch0 burst.
  - Required: next grant is ch3, then ch0.
- Backpressure:
  - Stimulus: arb_ready_out toggles 1,0,0,1 during the ch2 burst.
  - Required: arb_data_out/arb_ch_out/arb_last_out held stable while stalled. No beat lost or duplicated; 10 beats total.
- Valid gap in locked burst:
  - Stimulus: ch1 drops valid for 5 cycles after beat 3 while ch2 is valid.
  - Required: ch2 is never readied; ch1's burst resumes at beat 4 and completes to 10 before ch2 is granted.
